// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the core's SRAM port: access sizes, arbiter FSM states, requester IDs.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF = 12;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned BE_W       = DATA_W / 8;

   // Access size encodings match funct3[1:0]; 2'd3 is handled as a word.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IF_RESP = 2'd1,
      ST_D_RESP  = 2'd2
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_e;

   // Halves need an even byte offset and words need a zero offset; bytes are always aligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic res;
      case (size)
         SZ_B:    res = 1'b0;
         SZ_H:    res = off[0];
         default: res = |off;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and SRAM-side signal bundle of the memory port arbiter.
interface mem_port_arbiter_if #(parameter int unsigned ADDR_W = 12);

   logic               if_req;
   logic [31:0]        if_addr;
   logic               if_gnt;
   logic               if_rvalid;
   logic [31:0]        if_rdata;
   logic               if_err;

   logic               d_req;
   logic               d_we;
   logic [1:0]         d_size;
   logic               d_unsigned;
   logic [31:0]        d_addr;
   logic [31:0]        d_wdata;
   logic               d_gnt;
   logic               d_rvalid;
   logic [31:0]        d_rdata;
   logic               d_err;

   logic               mem_en;
   logic [3:0]         mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;

   // Requesters plus the SRAM, as seen from outside the arbiter.
   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   // The arbiter itself.
   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational sub-word lane steering: store byte enables/replication, load extract/extend, misalignment.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0]  i_st_off,
   input  logic [1:0]  i_st_size,
   input  logic [31:0] i_st_wdata,
   output logic [3:0]  o_st_be_c,
   output logic [31:0] o_st_wdata_c,
   output logic        o_misal_c,

   input  logic [1:0]  i_ld_off,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_rdata,
   output logic [31:0] o_ld_data_c
);

   logic [31:0] w_shifted;
   logic        w_sign;

   // Store side: enables follow the byte offset, data is replicated across all lanes.
   always_comb begin
      o_st_be_c    = 4'b1111;
      o_st_wdata_c = i_st_wdata;
      o_misal_c    = is_misaligned(i_st_size, i_st_off);
      case (i_st_size)
         SZ_B: begin
            o_st_be_c    = 4'b0001 << i_st_off;
            o_st_wdata_c = {4{i_st_wdata[7:0]}};
         end
         SZ_H: begin
            o_st_be_c    = 4'b0011 << i_st_off;
            o_st_wdata_c = {2{i_st_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};

   // Load side: bring the addressed lane down to bit 0, then sign- or zero-extend.
   always_comb begin
      w_sign      = 1'b0;
      o_ld_data_c = w_shifted;
      case (i_ld_size)
         SZ_B: begin
            w_sign      = w_shifted[7] & ~i_ld_unsigned;
            o_ld_data_c = {{24{w_sign}}, w_shifted[7:0]};
         end
         SZ_H: begin
            w_sign      = w_shifted[15] & ~i_ld_unsigned;
            o_ld_data_c = {{16{w_sign}}, w_shifted[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM port between instruction fetch and load/store.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   mem_port_arbiter_if.slave bus
);

   state_e      r_state;
   state_e      w_state_nxt;
   req_id_e     r_last;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_err;
   logic        r_we;

   logic        w_pick_d;
   logic [31:0] w_sel_addr;
   logic [1:0]  w_sel_size;
   logic        w_misal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata_rep;
   logic [31:0] w_ld_data;
   logic        w_gnt_if;
   logic        w_gnt_d;
   logic        w_if_rvalid;
   logic        w_d_rvalid;
   logic        w_unused_hi;

   // Data wins when it is the only requester, or on a tie when fetch was granted last.
   assign w_pick_d   = bus.d_req && (!bus.if_req || (r_last == REQ_IF));
   assign w_sel_addr = w_pick_d ? bus.d_addr : bus.if_addr;
   assign w_sel_size = w_pick_d ? bus.d_size : SZ_W;

   mem_lane_align u_lane_align (
      .i_st_off      (w_sel_addr[1:0]),
      .i_st_size     (w_sel_size),
      .i_st_wdata    (bus.d_wdata),
      .o_st_be_c     (w_be),
      .o_st_wdata_c  (w_wdata_rep),
      .o_misal_c     (w_misal),
      .i_ld_off      (r_off),
      .i_ld_size     (r_size),
      .i_ld_unsigned (r_unsigned),
      .i_ld_rdata    (bus.mem_rdata),
      .o_ld_data_c   (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Grant and issue happen in the same IDLE cycle; a misaligned access is granted but never reaches the SRAM.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_if    = 1'b0;
      w_gnt_d     = 1'b0;
      bus.mem_en  = 1'b0;
      bus.mem_we  = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            if (bus.if_req || bus.d_req) begin
               w_gnt_d     = w_pick_d;
               w_gnt_if    = !w_pick_d;
               bus.mem_en  = !w_misal;
               bus.mem_we  = (w_pick_d && bus.d_we && !w_misal) ? w_be : 4'b0000;
               w_state_nxt = w_pick_d ? ST_D_RESP : ST_IF_RESP;
            end
         end
         ST_IF_RESP: w_state_nxt = ST_IDLE;
         ST_D_RESP:  w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (rst) begin
         w_gnt_if   = 1'b0;
         w_gnt_d    = 1'b0;
         bus.mem_en = 1'b0;
         bus.mem_we = 4'b0000;
      end
   end

   // Capture who was served and how to shape the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last     <= REQ_D;
         r_off      <= 2'b00;
         r_size     <= SZ_W;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_we       <= 1'b0;
      end else if (w_gnt_if || w_gnt_d) begin
         r_last     <= w_gnt_d ? REQ_D : REQ_IF;
         r_off      <= w_sel_addr[1:0];
         r_size     <= w_sel_size;
         r_unsigned <= w_pick_d & bus.d_unsigned;
         r_err      <= w_misal;
         r_we       <= w_pick_d & bus.d_we;
      end
   end

   assign bus.if_gnt    = w_gnt_if;
   assign bus.d_gnt     = w_gnt_d;
   assign bus.mem_addr  = w_sel_addr[ADDR_W+1:2];
   assign bus.mem_wdata = w_wdata_rep;

   // Responses are suppressed while reset is held so an interrupted access never completes.
   assign w_if_rvalid   = (r_state == ST_IF_RESP) && !rst;
   assign w_d_rvalid    = (r_state == ST_D_RESP) && !rst;
   assign bus.if_rvalid = w_if_rvalid;
   assign bus.if_err    = w_if_rvalid & r_err;
   assign bus.if_rdata  = (w_if_rvalid && !r_err) ? bus.mem_rdata : 32'h0;
   assign bus.d_rvalid  = w_d_rvalid;
   assign bus.d_err     = w_d_rvalid & r_err;
   assign bus.d_rdata   = (w_d_rvalid && !r_err && !r_we) ? w_ld_data : 32'h0;

   // Byte-address bits above the SRAM word index alias.
   assign w_unused_hi = ^w_sel_addr[31:ADDR_W+2];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a byte-level behavioural model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW    = 12;
   localparam int unsigned DEPTH = 1 << AW;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic tb_init = 1'b1;

   mem_port_arbiter_if #(.ADDR_W(AW)) bus();

   mem_port_arbiter #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] sram    [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] init_word(input int i);
      return (i == 4) ? 32'h00500093 : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F);
   endfunction

   // Synchronous SRAM: read data appears the cycle after mem_en.
   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      end else if (bus.mem_en) begin
         bus.mem_rdata <= sram[bus.mem_addr];
         for (int b = 0; b < 4; b++)
            if (bus.mem_we[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int size_bytes(input logic [1:0] s);
      return (s == SZ_B) ? 1 : (s == SZ_H) ? 2 : 4;
   endfunction

   // Reference model state, only touched by the checker process.
   logic        m_busy = 1'b0, m_resp_d = 1'b0, m_exp_err = 1'b0, m_last_d = 1'b1;
   logic        m_took_if = 1'b0, m_took_d = 1'b0;
   logic [31:0] m_exp_rdata = 32'h0;
   logic        m_win, m_win_d, m_mis, m_we;
   logic [31:0] m_a, m_wd, m_v;
   logic [3:0]  m_be;
   int          m_n, m_off, m_idx;

   initial begin
      forever begin
         @(negedge clk);
         m_took_if = 1'b0;
         m_took_d  = 1'b0;
         if (tb_init) for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
         if (rst) begin
            check("rst_if_gnt",    32'(bus.if_gnt),    32'h0);
            check("rst_d_gnt",     32'(bus.d_gnt),     32'h0);
            check("rst_mem_en",    32'(bus.mem_en),    32'h0);
            check("rst_mem_we",    32'(bus.mem_we),    32'h0);
            check("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
            check("rst_d_rvalid",  32'(bus.d_rvalid),  32'h0);
            check("rst_if_rdata",  bus.if_rdata,       32'h0);
            check("rst_d_rdata",   bus.d_rdata,        32'h0);
            m_busy   = 1'b0;
            m_last_d = 1'b1;
         end else if (m_busy) begin
            check("rsp_if_gnt",    32'(bus.if_gnt),    32'h0);
            check("rsp_d_gnt",     32'(bus.d_gnt),     32'h0);
            check("rsp_mem_en",    32'(bus.mem_en),    32'h0);
            check("rsp_if_rvalid", 32'(bus.if_rvalid), 32'(!m_resp_d));
            check("rsp_d_rvalid",  32'(bus.d_rvalid),  32'(m_resp_d));
            if (m_resp_d) begin
               check("rsp_d_err",   32'(bus.d_err), 32'(m_exp_err));
               check("rsp_d_rdata", bus.d_rdata,    m_exp_rdata);
            end else begin
               check("rsp_if_err",   32'(bus.if_err), 32'(m_exp_err));
               check("rsp_if_rdata", bus.if_rdata,    m_exp_rdata);
            end
            m_busy = 1'b0;
         end else begin
            m_win = bus.if_req || bus.d_req;
            if (bus.if_req && bus.d_req) m_win_d = !m_last_d;
            else                         m_win_d = bus.d_req;
            check("gnt_if", 32'(bus.if_gnt), 32'(m_win && !m_win_d));
            check("gnt_d",  32'(bus.d_gnt),  32'(m_win && m_win_d));
            check("idle_if_rvalid", 32'(bus.if_rvalid), 32'h0);
            check("idle_d_rvalid",  32'(bus.d_rvalid),  32'h0);
            if (!m_win) begin
               check("idle_mem_en", 32'(bus.mem_en), 32'h0);
               check("idle_mem_we", 32'(bus.mem_we), 32'h0);
            end else begin
               m_a   = m_win_d ? bus.d_addr : bus.if_addr;
               m_n   = m_win_d ? size_bytes(bus.d_size) : 4;
               m_we  = m_win_d && bus.d_we;
               m_off = int'(m_a[1:0]);
               m_idx = int'(m_a[AW+1:2]);
               m_mis = (m_off % m_n) != 0;
               check("mem_en", 32'(bus.mem_en), 32'(!m_mis));
               if (!m_mis) check("mem_addr", 32'(bus.mem_addr), 32'(m_idx));
               m_be = 4'b0000;
               if (m_we && !m_mis) for (int k = 0; k < m_n; k++) m_be[m_off + k] = 1'b1;
               check("mem_we", 32'(bus.mem_we), 32'(m_be));
               m_v = 32'h0;
               if (m_mis) begin
                  m_v = 32'h0;
               end else if (m_we) begin
                  for (int l = 0; l < 4; l++) m_wd[8*l +: 8] = bus.d_wdata[8*(l % m_n) +: 8];
                  check("mem_wdata", bus.mem_wdata, m_wd);
                  for (int k = 0; k < m_n; k++)
                     ref_mem[m_idx][8*(m_off + k) +: 8] = bus.d_wdata[8*k +: 8];
               end else begin
                  for (int k = 0; k < m_n; k++) m_v[8*k +: 8] = ref_mem[m_idx][8*(m_off + k) +: 8];
                  if (m_win_d && !bus.d_unsigned && m_v[8*m_n - 1])
                     for (int k = m_n; k < 4; k++) m_v[8*k +: 8] = 8'hFF;
               end
               m_exp_rdata = m_v;
               m_exp_err   = m_mis;
               m_resp_d    = m_win_d;
               m_busy      = 1'b1;
               m_last_d    = m_win_d;
               m_took_if   = !m_win_d;
               m_took_d    = m_win_d;
            end
         end
      end
   end

   // Single fetch starting from IDLE, one cycle after a clock edge.
   task automatic f_op(input logic [31:0] a, input logic [31:0] exp_maddr, input logic [31:0] exp_rd);
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      @(negedge clk);
      check("f_gnt",      32'(bus.if_gnt),   32'h1);
      check("f_mem_en",   32'(bus.mem_en),   32'h1);
      check("f_mem_addr", 32'(bus.mem_addr), exp_maddr);
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      @(negedge clk);
      check("f_rvalid", 32'(bus.if_rvalid), 32'h1);
      check("f_rdata",  bus.if_rdata,       exp_rd);
      check("f_err",    32'(bus.if_err),    32'h0);
      @(posedge clk); #1;
   endtask

   // Single data access starting from IDLE, one cycle after a clock edge.
   task automatic d_op(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input logic exp_err);
      bus.d_req      = 1'b1;
      bus.d_we       = we;
      bus.d_size     = sz;
      bus.d_unsigned = uns;
      bus.d_addr     = a;
      bus.d_wdata    = wd;
      @(negedge clk);
      check("d_gnt",    32'(bus.d_gnt),  32'h1);
      check("d_mem_en", 32'(bus.mem_en), 32'(!exp_err));
      check("d_mem_we", 32'(bus.mem_we), 32'(exp_be));
      if (we && !exp_err) check("d_mem_wdata", bus.mem_wdata, exp_wd);
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      @(negedge clk);
      check("d_rvalid", 32'(bus.d_rvalid), 32'h1);
      check("d_err",    32'(bus.d_err),    32'(exp_err));
      check("d_rdata",  bus.d_rdata,       exp_rd);
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      a[AW+1:6] = '0;
      return a;
   endfunction

   logic [31:0] w8;

   initial begin
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_unsigned = 1'b0;
      bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      tb_init = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      f_op(32'h10, 32'h4, 32'h00500093);

      // Both requesters held from reset: fetch first, then strict alternation.
      rst = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_addr = 32'h0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("tie_if_gnt",    32'(bus.if_gnt),    32'((c % 4) == 0));
         check("tie_d_gnt",     32'(bus.d_gnt),     32'((c % 4) == 2));
         check("tie_if_rvalid", 32'(bus.if_rvalid), 32'((c % 4) == 1));
         check("tie_d_rvalid",  32'(bus.d_rvalid),  32'((c % 4) == 3));
         @(posedge clk); #1;
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;

      d_op(1'b1, SZ_B, 1'b0, 32'h23, 32'h000000AB, 4'b1000, 32'hABABABAB, 32'h0, 1'b0);
      d_op(1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 4'b0000, 32'h0, 32'hFFFFFFAB, 1'b0);
      d_op(1'b0, SZ_B, 1'b1, 32'h23, 32'h0, 4'b0000, 32'h0, 32'h000000AB, 1'b0);
      d_op(1'b1, SZ_H, 1'b0, 32'h22, 32'h00008001, 4'b1100, 32'h80018001, 32'h0, 1'b0);
      d_op(1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 4'b0000, 32'h0, 32'hFFFF8001, 1'b0);
      d_op(1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 4'b0000, 32'h0, 32'h00008001, 1'b0);
      d_op(1'b0, SZ_W, 1'b0, 32'h21, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
      d_op(1'b1, SZ_W, 1'b0, 32'h21, 32'hDEADBEEF, 4'b0000, 32'h0, 32'h0, 1'b1);
      w8 = init_word(8);
      d_op(1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h0, {16'h8001, w8[15:0]}, 1'b0);

      // Reset lands in the data response cycle.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = SZ_W; bus.d_addr = 32'h4;
      @(negedge clk);
      check("rr_d_gnt", 32'(bus.d_gnt), 32'h1);
      @(posedge clk); #1;
      rst = 1'b1;
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      @(negedge clk);
      check("rr_no_rvalid", 32'(bus.d_rvalid), 32'h0);
      check("rr_no_gnt",    32'(bus.if_gnt | bus.d_gnt), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rr_if_first", 32'(bus.if_gnt), 32'h1);
      check("rr_d_waits",  32'(bus.d_gnt),  32'h0);
      @(posedge clk); #1;
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      @(posedge clk); #1;

      // Random traffic with holds, withdrawals and back-to-back requests.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (m_took_if || !bus.if_req) begin
            bus.if_req  = 1'($urandom_range(0, 1));
            bus.if_addr = rand_addr();
            if ($urandom_range(0, 7) != 0) bus.if_addr[1:0] = 2'b00;
         end else if ($urandom_range(0, 9) == 0) begin
            bus.if_req = 1'b0;
         end
         if (m_took_d || !bus.d_req) begin
            bus.d_req      = 1'($urandom_range(0, 1));
            bus.d_we       = 1'($urandom_range(0, 1));
            bus.d_size     = 2'($urandom_range(0, 3));
            bus.d_unsigned = 1'($urandom_range(0, 1));
            bus.d_addr     = rand_addr();
            bus.d_wdata    = $urandom;
         end else if ($urandom_range(0, 9) == 0) begin
            bus.d_req = 1'b0;
         end
         @(posedge clk); #1;
      end
      bus.if_req = 1'b0; bus.d_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
